mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single exmem port between the CPU statemachine and a second read-only
//  requester (video/hex-display scanner). Decodes I/O space, fixed at adr[15:14]==IO_PREFIX,
//  and routes those CPU accesses to the I/O strobes instead of memory.
//  Sits in top between SM/DP, exmem and the I/O devices.
//  Sequences every access as a fixed 3-state transaction with a one-cycle ack pulse.
// PARAMETERS
//  ADDR_W     16     address width
//  DATA_W     16     data width
//  IO_PREFIX  2'b11  adr[ADDR_W-1:ADDR_W-2] value that selects I/O space
//  VID_STARVE 4      CPU grants allowed while vid_req waits before video is forced in
// PORTS
//  clk        in   1       system clock; all state on rising edge
//  rst        in   1       asynchronous, active-low reset
//  cpu_req    in   1       CPU access request, level, held until cpu_ack
//  cpu_we     in   1       1=write, 0=read; stable while cpu_req high
//  cpu_adr    in   ADDR_W  CPU address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_ack    out  1       one-cycle pulse: access complete
//  cpu_rdata  out  DATA_W  read data; valid while cpu_ack high, held after
//  vid_req    in   1       video read request, level, held until vid_ack
//  vid_adr    in   ADDR_W  video address
//  vid_ack    out  1       one-cycle pulse: read complete
//  vid_rdata  out  DATA_W  read data; valid while vid_ack high, held after
//  mem_en     out  1       exmem enable
//  mem_read   out  1       exmem read strobe
//  mem_write  out  1       exmem write strobe
//  mem_adr    out  ADDR_W  exmem address
//  mem_wdata  out  DATA_W  exmem write data
//  mem_rdata  in   DATA_W  exmem read data; valid by end of ISSUE cycle (exmem on ~clk)
//  io_sel     out  1       I/O access strobe, one cycle
//  io_we      out  1       I/O write qualifier
//  io_rdata   in   DATA_W  I/O read data; valid by end of ISSUE cycle
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, vid_wait=0; every output 0, including both rdata regs.
//  - States: IDLE -> ISSUE -> ACK -> IDLE. Registered owner bit: 0=CPU, 1=VID.
//  - IDLE: sample requests.
//    - Neither high: stay.
//    - One high: grant it.
//    - Both high: grant VID if vid_wait==VID_STARVE, else CPU.
//  - ISSUE, one cycle; outputs registered, driven only in this cycle:
//    - mem_adr, mem_wdata, mem_read=~we, mem_write=we, mem_en=1.
//    - CPU with I/O-space address: mem_en, mem_read and mem_write stay 0;
//      io_sel=1, io_we=cpu_we.
//    - VID is always a read. A VID address in I/O space makes no access and returns 0.
//  - End of ISSUE: the owner's rdata register captures mem_rdata, or io_rdata for a CPU
//    I/O read. Write transactions leave rdata unchanged.
//  - ACK, one cycle: owner's ack=1, all mem_*/io_* strobes 0. Next state is IDLE.
//    Requester must drop req during ACK; req still high in IDLE starts a new transaction.
//  - Latency: req high in cycle 0 (IDLE) -> ISSUE in cycle 1 -> ack in cycle 2.
//    Peak rate is 1 transaction per 3 cycles.
//  - vid_wait, saturating:
//    - +1 on each CPU grant made while vid_req is high.
//    - Cleared on every VID grant.
//    - Never exceeds VID_STARVE.
//  - Requester inputs change only in IDLE, ACK or after ack. Changes during ISSUE are ignored:
//    address, data and we are latched at grant.
//  - Both acks are never high together. Strobes are never high outside ISSUE.
//  - Reset asserted mid-transaction aborts it: no ack is issued, strobes drop immediately.
// TESTING
//  1 CPU read adr=16'h0010, mem_rdata=16'hBEEF
//    -> mem_read=1, mem_adr=16'h0010 in cycle 1; cpu_ack=1, cpu_rdata=16'hBEEF in cycle 2.
//  2 CPU write adr=16'h0020, wdata=16'h1234 -> mem_write=1, mem_wdata=16'h1234 in cycle 1;
//    cpu_ack in cycle 2; cpu_rdata unchanged.
//  3 CPU write adr=16'hC004 -> io_sel=1, io_we=1, mem_en=0 in cycle 1; cpu_ack in cycle 2.
//    CPU read of 16'hC004 with io_rdata=16'h00A5 -> cpu_rdata=16'h00A5.
//  4 cpu_req and vid_req held continuously, VID_STARVE=2: grant order CPU,CPU,VID,CPU,CPU,VID.
//    Acks are never simultaneous.
//  5 Video read adr=16'hC000 -> no mem/io strobe; vid_ack with vid_rdata=16'h0000.
//  6 rst low during ISSUE of a CPU read -> all outputs 0 immediately; no cpu_ack.
//    After release with cpu_req high, a fresh ISSUE follows.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares the exmem port between the CPU and a read-only video scanner, and decodes
// I/O space. Each access runs a fixed IDLE -> ISSUE -> ACK sequence with registered strobes.
module mem_arbiter #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 16,
   parameter logic [1:0]  IO_PREFIX  = 2'b11,
   parameter int unsigned VID_STARVE = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_adr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_adr,
   output logic              vid_ack,
   output logic [DATA_W-1:0] vid_rdata,
   output logic              mem_en,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              io_sel,
   output logic              io_we,
   input  logic [DATA_W-1:0] io_rdata
);

   localparam int unsigned WAIT_W = (VID_STARVE < 1) ? 1 : $clog2(VID_STARVE + 1);
   localparam logic [WAIT_W-1:0] STARVE_W = WAIT_W'(VID_STARVE);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK} state_t;

   state_t            state_q;
   logic              owner_q;
   logic              we_q;
   logic [WAIT_W-1:0] vid_wait_q, vid_wait_d;
   logic              cpu_ack_q, vid_ack_q;
   logic [DATA_W-1:0] cpu_rdata_q, vid_rdata_q;
   logic              mem_en_q, mem_read_q, mem_write_q;
   logic [ADDR_W-1:0] mem_adr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              io_sel_q, io_we_q;

   logic cpu_io, vid_io, gnt_cpu, gnt_vid;

   always_comb begin
      cpu_io  = (cpu_adr[ADDR_W-1 -: 2] == IO_PREFIX);
      vid_io  = (vid_adr[ADDR_W-1 -: 2] == IO_PREFIX);
      gnt_vid = (state_q == S_IDLE) && vid_req && (!cpu_req || (vid_wait_q == STARVE_W));
      gnt_cpu = (state_q == S_IDLE) && cpu_req && !gnt_vid;
      vid_wait_d = vid_wait_q;
      if (gnt_vid)
         vid_wait_d = '0;
      else if (gnt_cpu && vid_req && (vid_wait_q != STARVE_W))
         vid_wait_d = vid_wait_q + WAIT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         vid_wait_q  <= '0;
         cpu_ack_q   <= 1'b0;
         vid_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         vid_rdata_q <= '0;
         mem_en_q    <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_adr_q   <= '0;
         mem_wdata_q <= '0;
         io_sel_q    <= 1'b0;
         io_we_q     <= 1'b0;
      end else begin
         vid_wait_q <= vid_wait_d;
         unique case (state_q)
            S_IDLE: begin
               if (gnt_vid) begin
                  state_q     <= S_ISSUE;
                  owner_q     <= 1'b1;
                  we_q        <= 1'b0;
                  mem_adr_q   <= vid_adr;
                  mem_wdata_q <= '0;
                  mem_en_q    <= !vid_io;
                  mem_read_q  <= !vid_io;
               end else if (gnt_cpu) begin
                  state_q     <= S_ISSUE;
                  owner_q     <= 1'b0;
                  we_q        <= cpu_we;
                  mem_adr_q   <= cpu_adr;
                  mem_wdata_q <= cpu_wdata;
                  mem_en_q    <= !cpu_io;
                  mem_read_q  <= !cpu_io && !cpu_we;
                  mem_write_q <= !cpu_io && cpu_we;
                  io_sel_q    <= cpu_io;
                  io_we_q     <= cpu_io && cpu_we;
               end
            end
            S_ISSUE: begin
               state_q     <= S_ACK;
               mem_en_q    <= 1'b0;
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
               mem_adr_q   <= '0;
               mem_wdata_q <= '0;
               io_sel_q    <= 1'b0;
               io_we_q     <= 1'b0;
               // A video access with mem_en low was an I/O-space address: it returns zero.
               if (owner_q) begin
                  vid_ack_q   <= 1'b1;
                  vid_rdata_q <= mem_en_q ? mem_rdata : '0;
               end else begin
                  cpu_ack_q <= 1'b1;
                  if (!we_q)
                     cpu_rdata_q <= io_sel_q ? io_rdata : mem_rdata;
               end
            end
            S_ACK: begin
               state_q   <= S_IDLE;
               cpu_ack_q <= 1'b0;
               vid_ack_q <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cpu_ack   = cpu_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign vid_ack   = vid_ack_q;
   assign vid_rdata = vid_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_adr   = mem_adr_q;
   assign mem_wdata = mem_wdata_q;
   assign io_sel    = io_sel_q;
   assign io_we     = io_we_q;

endmodule
